// File: rtl/ped_pkg.sv
// ---------------------------------------------------------------------------
// ped_pkg
// Shared definitions for the pedestrian request generator: controller light
// codes, the request FSM state type and the width of the small counters.
// No ports; imported by ped_request_gen_if, ped_debounce and ped_request_gen.
// ---------------------------------------------------------------------------
package ped_pkg;

   localparam int CNT_W = 4;

   localparam logic [2:0] GREEN     = 3'b111;
   localparam logic [2:0] WAITING_R = 3'b010;
   localparam logic [2:0] RED       = 3'b000;

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      REQUEST,
      SERVED,
      LOCKOUT
   } ped_state_e;

endpackage

// File: rtl/ped_request_gen_if.sv
// ---------------------------------------------------------------------------
// ped_request_gen_if
// Groups the controller-facing signals of the pedestrian request generator.
//   lights      : controller light code (GREEN / WAITING_R / RED)
//   request     : request to the controller, held until granted
//   pending     : accepted press not yet served
//   lockout     : presses currently ignored
//   press_count : accepted presses modulo 16
// Modports: master = request generator side, slave = controller side.
// ---------------------------------------------------------------------------
interface ped_request_gen_if;
   import ped_pkg::*;

   logic [2:0]       lights;
   logic             request;
   logic             pending;
   logic             lockout;
   logic [CNT_W-1:0] press_count;

   modport master (
      input  lights,
      output request,
      output pending,
      output lockout,
      output press_count
   );

   modport slave (
      output lights,
      input  request,
      input  pending,
      input  lockout,
      input  press_count
   );

endinterface

// File: rtl/ped_debounce.sv
// ---------------------------------------------------------------------------
// ped_debounce
// Two-flop synchronizer, debounce counter and re-arm flag for the crosswalk
// button. The three outputs are single-cycle pulses built only from
// registered state, so they add no input-to-output combinational path.
//   clk, reset_n      : clock, synchronous active-low reset
//   button_raw_i      : asynchronous bouncy button
//   hold_off_i        : high while the request FSM ignores the button
//   press_start_o     : a qualifying press began (counter loaded with 1)
//   press_abort_o     : the press dropped before being accepted
//   press_accepted_o  : the press was held long enough and is accepted
// ---------------------------------------------------------------------------
module ped_debounce
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic button_raw_i,
   input  logic hold_off_i,
   output logic press_start_o,
   output logic press_abort_o,
   output logic press_accepted_o
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);

   logic             btnMeta_q, btnSync_q;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cntIdle;

   // A zero counter means no press is being timed (the FSM is in IDLE).
   assign cntIdle          = (cnt_q == '0);
   assign press_start_o    = !hold_off_i && cntIdle && btnSync_q && armed_q;
   assign press_abort_o    = !hold_off_i && !cntIdle && !btnSync_q;
   assign press_accepted_o = !hold_off_i && !cntIdle && btnSync_q && (cnt_q == DB_LAST);

   // The armed flag only re-arms on a low sample while idle, so a button held
   // through a whole crossing cannot raise a second request.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (hold_off_i) begin
         cnt_d = '0;
      end else if (press_start_o) begin
         cnt_d = CNT_W'(1);
      end else if (press_abort_o || press_accepted_o) begin
         cnt_d = '0;
      end else if (!cntIdle) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (press_accepted_o) begin
         armed_d = 1'b0;
      end else if (!hold_off_i && cntIdle && !btnSync_q) begin
         armed_d = 1'b1;
      end
   end

   // Synchronizer and debounce state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btnMeta_q <= 1'b0;
         btnSync_q <= 1'b0;
         cnt_q     <= '0;
         armed_q   <= 1'b1;
      end else begin
         btnMeta_q <= button_raw_i;
         btnSync_q <= btnMeta_q;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
      end
   end

endmodule

// File: rtl/ped_request_gen.sv
// ---------------------------------------------------------------------------
// ped_request_gen
// Pedestrian request generator: debounced button press -> held request until
// the controller shows GREEN, then a lockout once the crossing ends.
//   clk         : clock, rising edge
//   reset_n     : synchronous active-low reset
//   button_raw  : asynchronous bouncy crosswalk button
//   ctrl        : ped_request_gen_if.master (lights in; request, pending,
//                 lockout, press_count out; all outputs registered)
// Parameters: DEBOUNCE_CYCLES (1..15), LOCKOUT_CYCLES (1..15).
// Configuration macro: PED_PRESS_COUNT_EN builds the press counter; when
// undefined press_count is tied to zero.
// ---------------------------------------------------------------------------
module ped_request_gen
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              button_raw,
   ped_request_gen_if.master ctrl
);

   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);

   ped_state_e       state_q, state_d;
   logic [CNT_W-1:0] lockCnt_q, lockCnt_d;
   logic             absorbed_q, absorbed_d;
   logic             request_q, request_d;
   logic             pending_q, pending_d;
   logic             lockout_q, lockout_d;
   logic             pressStart, pressAbort, pressAccepted;
   logic             holdOff, lightsGreen;

   // Any code other than GREEN, including illegal ones, counts as not green.
   assign lightsGreen = (ctrl.lights == GREEN);
   assign holdOff     = (state_q == REQUEST) || (state_q == SERVED) || (state_q == LOCKOUT);

   ped_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk              (clk),
      .reset_n          (reset_n),
      .button_raw_i     (button_raw),
      .hold_off_i       (holdOff),
      .press_start_o    (pressStart),
      .press_abort_o    (pressAbort),
      .press_accepted_o (pressAccepted)
   );

   // Next state and next outputs. absorbed marks a press accepted while the
   // lights were already GREEN; it keeps pending high through SERVED.
   always_comb begin
      state_d    = state_q;
      lockCnt_d  = lockCnt_q;
      absorbed_d = absorbed_q;
      case (state_q)
         IDLE: begin
            if (pressStart) state_d = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (pressAbort) begin
               state_d = IDLE;
            end else if (pressAccepted) begin
               if (lightsGreen) begin
                  state_d    = SERVED;
                  absorbed_d = 1'b1;
               end else begin
                  state_d = REQUEST;
               end
            end
         end
         REQUEST: begin
            absorbed_d = 1'b0;
            if (lightsGreen) state_d = SERVED;
         end
         SERVED: begin
            if (!lightsGreen) begin
               state_d    = LOCKOUT;
               lockCnt_d  = LOCK_LOAD;
               absorbed_d = 1'b0;
            end
         end
         LOCKOUT: begin
            if (lockCnt_q <= CNT_W'(1)) begin
               state_d   = IDLE;
               lockCnt_d = '0;
            end else begin
               lockCnt_d = lockCnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      request_d = (state_d == REQUEST);
      pending_d = request_d || ((state_d == SERVED) && absorbed_d);
      lockout_d = (state_d == LOCKOUT);
   end

   // FSM state, lockout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         lockCnt_q  <= '0;
         absorbed_q <= 1'b0;
         request_q  <= 1'b0;
         pending_q  <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lockCnt_q  <= lockCnt_d;
         absorbed_q <= absorbed_d;
         request_q  <= request_d;
         pending_q  <= pending_d;
         lockout_q  <= lockout_d;
      end
   end

   assign ctrl.request = request_q;
   assign ctrl.pending = pending_q;
   assign ctrl.lockout = lockout_q;

`ifdef PED_PRESS_COUNT_EN
   logic [CNT_W-1:0] pressCnt_q, pressCnt_d;

   // One increment per accepted press, whether it became a request or was
   // absorbed by an already-green light; wraps silently.
   always_comb begin
      pressCnt_d = pressCnt_q;
      if ((state_q == DEBOUNCE) && pressAccepted) pressCnt_d = pressCnt_q + CNT_W'(1);
   end

   // Press counter register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pressCnt_q <= '0;
      end else begin
         pressCnt_q <= pressCnt_d;
      end
   end

   assign ctrl.press_count = pressCnt_q;
`else
   assign ctrl.press_count = '0;
`endif

endmodule

// File: tb/tb_ped_request_gen.sv
// ---------------------------------------------------------------------------
// tb_ped_request_gen
// Self-checking bench for ped_request_gen with default parameters.
// ---------------------------------------------------------------------------
module tb_ped_request_gen;
   import ped_pkg::*;

   localparam int DB = 4;
   localparam int LO = 7;

   logic clk        = 1'b0;
   logic reset_n    = 1'b0;
   logic button_raw = 1'b0;

   int testsRun    = 0;
   int testsFailed = 0;

   ped_request_gen_if bus ();

   ped_request_gen #(
      .DEBOUNCE_CYCLES (DB),
      .LOCKOUT_CYCLES  (LO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .button_raw (button_raw),
      .ctrl       (bus)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Behavioural model: the button is seen two edges late; a press counts once
   // DB+1 consecutive high samples arrive while armed and nothing else is busy.
   bit mS1, mS2, mArmed, mReq, mServed, mAbsorbed, modelValid;
   int mRun, mLock, mPresses;

   function automatic logic [3:0] lit(input int v);
`ifdef PED_PRESS_COUNT_EN
      return 4'(v % 16);
`else
      return 4'(v - v);
`endif
   endfunction

   task automatic modelStep();
      bit btnS;
      bit green;
      if (!reset_n) begin
         mS1 = 0; mS2 = 0; mArmed = 1; mReq = 0; mServed = 0; mAbsorbed = 0;
         mRun = 0; mLock = 0; mPresses = 0; modelValid = 1;
         return;
      end
      green = (bus.lights == GREEN);
      btnS  = mS2;
      mS2   = mS1;
      mS1   = button_raw;
      if (mLock > 0) begin
         mLock--;
      end else if (mServed) begin
         if (!green) begin mServed = 0; mAbsorbed = 0; mLock = LO; end
      end else if (mReq) begin
         if (green) begin mReq = 0; mServed = 1; end
      end else if (!btnS) begin
         if (mRun == 0) mArmed = 1;
         mRun = 0;
      end else if (mArmed) begin
         mRun++;
         if (mRun == DB + 1) begin
            mPresses++;
            mArmed = 0;
            mRun   = 0;
            if (green) begin mServed = 1; mAbsorbed = 1; end
            else mReq = 1;
         end
      end
   endtask

   // Model advances on every rising edge using the same sampled inputs.
   initial forever begin
      @(posedge clk);
      modelStep();
   end

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model on each falling edge.
   initial forever begin
      @(negedge clk);
      if (modelValid) begin
         checkOutput("model.request", {3'b0, bus.request}, {3'b0, mReq});
         checkOutput("model.pending", {3'b0, bus.pending}, {3'b0, mReq || (mServed && mAbsorbed)});
         checkOutput("model.lockout", {3'b0, bus.lockout}, {3'b0, mLock > 0});
         checkOutput("model.press_count", bus.press_count, lit(mPresses));
      end
   end

   task automatic applyStimulus(input bit raw, input logic [2:0] l, input int n);
      for (int i = 0; i < n; i++) begin
         button_raw = raw;
         bus.lights = l;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      reset_n    = 1'b0;
      button_raw = 1'b0;
      bus.lights = RED;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset, then a clean press held from edge 0 with RED lights.
      doReset();
      checkOutput("reset.request", {3'b0, bus.request}, 4'd0);
      checkOutput("reset.lockout", {3'b0, bus.lockout}, 4'd0);
      checkOutput("reset.press_count", bus.press_count, 4'd0);
      applyStimulus(1, RED, 6);
      checkOutput("press.request_e5", {3'b0, bus.request}, 4'd0);
      applyStimulus(1, RED, 1);
      checkOutput("press.request_e6", {3'b0, bus.request}, 4'd1);
      checkOutput("press.pending_e6", {3'b0, bus.pending}, 4'd1);
      checkOutput("press.count_e6", bus.press_count, lit(1));

      // Grant at edge 10, lights back to RED at edge 14.
      applyStimulus(0, RED, 3);
      applyStimulus(0, GREEN, 1);
      checkOutput("grant.request_e10", {3'b0, bus.request}, 4'd0);
      applyStimulus(0, GREEN, 3);
      checkOutput("grant.lockout_e13", {3'b0, bus.lockout}, 4'd0);
      applyStimulus(0, RED, 1);
      checkOutput("grant.lockout_e14", {3'b0, bus.lockout}, 4'd1);
      applyStimulus(0, RED, 6);
      checkOutput("grant.lockout_e20", {3'b0, bus.lockout}, 4'd1);
      applyStimulus(0, RED, 1);
      checkOutput("grant.lockout_e21", {3'b0, bus.lockout}, 4'd0);

      // Bouncing button never produces a request.
      doReset();
      applyStimulus(1, RED, 1);
      applyStimulus(0, RED, 1);
      applyStimulus(1, RED, 2);
      applyStimulus(0, RED, 9);
      checkOutput("bounce.request", {3'b0, bus.request}, 4'd0);
      checkOutput("bounce.count", bus.press_count, 4'd0);

      // Held button through grant and lockout, then release and press again.
      doReset();
      applyStimulus(1, RED, 7);
      applyStimulus(1, GREEN, 3);
      applyStimulus(1, RED, 1);
      checkOutput("held.lockout_e10", {3'b0, bus.lockout}, 4'd1);
      applyStimulus(1, RED, 20);
      checkOutput("held.request_e30", {3'b0, bus.request}, 4'd0);
      checkOutput("held.lockout_e30", {3'b0, bus.lockout}, 4'd0);
      applyStimulus(0, RED, 1);
      applyStimulus(1, RED, 6);
      checkOutput("held.request_e37", {3'b0, bus.request}, 4'd0);
      applyStimulus(1, RED, 1);
      checkOutput("held.request_e38", {3'b0, bus.request}, 4'd1);
      checkOutput("held.count_e38", bus.press_count, lit(2));

      // Press accepted while GREEN is absorbed straight into SERVED.
      doReset();
      applyStimulus(1, GREEN, 7);
      checkOutput("green.request", {3'b0, bus.request}, 4'd0);
      checkOutput("green.pending", {3'b0, bus.pending}, 4'd1);
      checkOutput("green.count", bus.press_count, lit(1));
      applyStimulus(0, RED, 1);
      checkOutput("green.lockout", {3'b0, bus.lockout}, 4'd1);
      checkOutput("green.pending_after", {3'b0, bus.pending}, 4'd0);

      // Reset while REQUEST, then again while LOCKOUT.
      doReset();
      applyStimulus(1, RED, 7);
      checkOutput("rstreq.request_before", {3'b0, bus.request}, 4'd1);
      reset_n = 1'b0;
      applyStimulus(1, RED, 1);
      reset_n = 1'b1;
      checkOutput("rstreq.request", {3'b0, bus.request}, 4'd0);
      checkOutput("rstreq.pending", {3'b0, bus.pending}, 4'd0);
      checkOutput("rstreq.count", bus.press_count, 4'd0);
      applyStimulus(1, RED, 7);
      applyStimulus(0, GREEN, 1);
      applyStimulus(0, RED, 1);
      checkOutput("rstlock.lockout_before", {3'b0, bus.lockout}, 4'd1);
      reset_n = 1'b0;
      applyStimulus(0, RED, 1);
      reset_n = 1'b1;
      checkOutput("rstlock.lockout", {3'b0, bus.lockout}, 4'd0);

      // Sixteen absorbed presses wrap the counter back to zero.
      doReset();
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1, GREEN, 7);
         if (i == 15) checkOutput("wrap.count15", bus.press_count, lit(15));
         applyStimulus(0, RED, 12);
      end
      checkOutput("wrap.count16", bus.press_count, lit(16));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ped_request_gen.md
# ped_request_gen

Pedestrian-side request generator for the traffic-light controller. It takes a raw, bouncy crosswalk button, synchronizes and debounces it, and presents a clean request that is held until the controller grants the crossing (lights show GREEN). After the crossing ends, a lockout period applies so that a user holding or spamming the button cannot retrigger the controller. It sits between the physical button and the controller's `button` input, and observes the controller's `lights` output.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high cycles required to accept a press; legal range 1..15.
- `LOCKOUT_CYCLES`, default 7: number of cycles after a served crossing during which presses are ignored; legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `button_raw` input 1: asynchronous, bouncy button.
- `lights` input 3: controller light code (GREEN 3'b111, WAITING_R 3'b010, RED 3'b000).
- `request` output 1: request to the controller; held until granted.
- `pending` output 1: a debounced press is accepted and not yet served (request high, or absorbed while in SERVED).
- `lockout` output 1: high while presses are ignored.
- `press_count` output 4: number of accepted presses, modulo 16.

## Operation
- Synchronizer: 2-flop on `button_raw` gives `btn_s`.
- `armed` flag: cleared when a press is accepted; set when `btn_s` is sampled low in IDLE. Presses are accepted only while `armed`=1. A held button therefore never produces a second request.
- FSM states:
  - IDLE: if `btn_s`=1 and `armed`, go to DEBOUNCE with the counter at 1.
  - DEBOUNCE: if `btn_s`=0, return to IDLE (glitch) and clear the counter. If the counter reaches `DEBOUNCE_CYCLES`, the press is accepted: `press_count`++ and `armed`=0. The next state is REQUEST, or SERVED if `lights`==GREEN at that edge; in the SERVED case the press is absorbed and `request` never rises.
  - REQUEST: `request`=1. If `lights`==GREEN, go to SERVED.
  - SERVED: `request`=0. Wait for `lights`!=GREEN, then go to LOCKOUT and load the lockout counter.
  - LOCKOUT: `lockout`=1. `button_raw` is ignored. After `LOCKOUT_CYCLES` cycles, go to IDLE.
- `lights` values other than the three legal codes are treated as "not GREEN".
- `press_count` wraps from 15 to 0 with no flag.

## Timing
- Reset (`reset_n`=0 at an edge) applies to all state: FSM IDLE, synchronizer 0, counters 0, `armed`=1, `request`=0, `pending`=0, `lockout`=0, `press_count`=0. This holds mid-operation as well, including during REQUEST and LOCKOUT.
- Press latency: if `button_raw` is first sampled high at edge N and stays high, `request` is high after edge N+2+`DEBOUNCE_CYCLES`.
- Grant latency: if `lights`==GREEN is sampled at edge M, `request` is low after edge M.
- Lockout: `lockout` is high after the edge at which `lights`!=GREEN is first seen in SERVED. It stays high for exactly `LOCKOUT_CYCLES` cycles.
- All outputs are registered; there are no combinational paths from input to output.
- A press accepted while `lights`==GREEN and a grant in the same cycle both resolve to SERVED, with a single `press_count` increment.

## Configuration
- `PED_PRESS_COUNT_EN` defined: the 4-bit `press_count` register is built and counts as described above.
- `PED_PRESS_COUNT_EN` undefined: the register is not built and `press_count` is tied to 4'b0000. All other behaviour is identical.

## Structure
- Shared package `ped_pkg`:
  - light code constants GREEN, WAITING_R, RED;
  - FSM state typedef IDLE/DEBOUNCE/REQUEST/SERVED/LOCKOUT;
  - 4-bit counter width constant.
- Sub-module `ped_debounce` contains the synchronizer, the debounce counter and the `armed` flag. It produces a one-cycle `press_accepted` pulse and takes a `hold_off` input, driven from LOCKOUT/REQUEST/SERVED. The top level holds the FSM, the lockout counter and `press_count`.

## Test plan
- Reset then clean press: `button_raw`=1 from edge 0, `lights`=RED. Then `request`=1 after edge 6, `pending`=1, `press_count`=1.
- Bounce: `button_raw` toggles 1,0,1,1,0 starting at edge 0, then stays 0. Then `request` stays 0 and `press_count` stays 0.
- Grant and lockout:
  - with `request` high, drive `lights`=GREEN at edge 10 and RED at edge 14;
  - `request`=0 after edge 10;
  - `lockout`=1 after edge 14 through edge 21, and 0 after edge 21.
- Held button: `button_raw` stays 1 throughout a full grant and lockout. Afterwards there is no second request. Releasing for 1 cycle and pressing again yields `request` after the debounce latency, and `press_count`=2.
- Press during GREEN: `lights`=GREEN and a clean press. Then `request` never rises, `press_count` increments, and the FSM goes to SERVED and then LOCKOUT when `lights` returns to RED.
- Reset mid-REQUEST: `reset_n`=0 for 1 cycle while `request`=1. Then all outputs are 0 next cycle and `press_count`=0.
